// File: rtl/jtkcpu_idx_pkg.sv
// Shared constants and types for the indexed-addressing engine:
// postbyte layout, mode/register/accumulator codes and FSM states.
package jtkcpu_idx_pkg;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  localparam logic [2:0] MODE_POSTINC1 = 3'd0;
  localparam logic [2:0] MODE_POSTINC2 = 3'd1;
  localparam logic [2:0] MODE_PREDEC1  = 3'd2;
  localparam logic [2:0] MODE_PREDEC2  = 3'd3;
  localparam logic [2:0] MODE_ACC      = 3'd4;
  localparam logic [2:0] MODE_N8       = 3'd5;
  localparam logic [2:0] MODE_N16      = 3'd6;
  localparam logic [2:0] MODE_EXT      = 3'd7;

  localparam logic [1:0] REG_X = 2'd0;
  localparam logic [1:0] REG_Y = 2'd1;
  localparam logic [1:0] REG_U = 2'd2;
  localparam logic [1:0] REG_S = 2'd3;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_A    = 2'd1;
  localparam logic [1:0] ACC_B    = 2'd2;
  localparam logic [1:0] ACC_D    = 2'd3;

  typedef struct packed {
    logic       ind;
    logic [2:0] mode;
    logic [1:0] acc;
    logic [1:0] rsel;
  } postbyte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POSTB,
    ST_OFS_HI,
    ST_OFS_LO,
    ST_CALC,
    ST_IND_HI,
    ST_IND_LO,
    ST_DONE
  } state_t;

  function automatic logic [AW-1:0] sext8(input logic [DW-1:0] v);
    return {{(AW - DW){v[DW-1]}}, v};
  endfunction

endpackage

// File: rtl/jtkcpu_idx_calc.sv
// Combinational EA adder/mux: base register plus offset selected by the
// postbyte, and the auto-increment/decrement writeback value.
module jtkcpu_idx_calc
  import jtkcpu_idx_pkg::*;
(
  input  postbyte_t     postb,
  input  logic [AW-1:0] x,
  input  logic [AW-1:0] y,
  input  logic [AW-1:0] u,
  input  logic [AW-1:0] s,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] ofs,
  output logic [AW-1:0] ea_pre,
  output logic [AW-1:0] upd_val
);

  logic [AW-1:0] base;
  logic [AW-1:0] acc_ofs;

  always_comb begin
    case (postb.rsel)
      REG_X:   base = x;
      REG_Y:   base = y;
      REG_U:   base = u;
      default: base = s;
    endcase
  end

  // A and B are signed offsets, D is a plain 16-bit add
  always_comb begin
    case (postb.acc)
      ACC_A:   acc_ofs = sext8(a);
      ACC_B:   acc_ofs = sext8(b);
      ACC_D:   acc_ofs = {a, b};
      default: acc_ofs = '0;
    endcase
  end

  always_comb begin
    ea_pre  = base;
    upd_val = base;
    case (postb.mode)
      MODE_POSTINC1: upd_val = base + AW'(1);
      MODE_POSTINC2: upd_val = base + AW'(2);
      MODE_PREDEC1: begin
        ea_pre  = base - AW'(1);
        upd_val = base - AW'(1);
      end
      MODE_PREDEC2: begin
        ea_pre  = base - AW'(2);
        upd_val = base - AW'(2);
      end
      MODE_ACC: ea_pre = base + acc_ofs;
      MODE_N8:  ea_pre = base + sext8(ofs[DW-1:0]);
      MODE_N16: ea_pre = base + ofs;
      default:  ea_pre = ofs;
    endcase
  end

endmodule

// File: rtl/jtkcpu_idx.sv
// Indexed-addressing engine: fetches postbyte/offsets from the PC stream,
// forms the EA, does the optional indirect fetch and index writeback.
module jtkcpu_idx
  import jtkcpu_idx_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          idx_en,
  input  logic [DW-1:0] din,
  input  logic          mem_busy,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] x,
  input  logic [AW-1:0] y,
  input  logic [AW-1:0] u,
  input  logic [AW-1:0] s,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          rd,
  output logic [AW-1:0] rd_addr,
  output logic          pc_inc,
  output logic          idx_busy,
  output logic [AW-1:0] ea,
  output logic          upd_en,
  output logic [1:0]    upd_sel,
  output logic [AW-1:0] upd_val
);

  state_t        state, state_nx;
  postbyte_t     postb, din_pb;
  logic [AW-1:0] ofs;
  logic [AW-1:0] ea_pre;
  logic [AW-1:0] calc_upd;
  logic [DW-1:0] ind_hi;

  assign din_pb = postbyte_t'(din);

  jtkcpu_idx_calc u_calc (
    .postb   (postb),
    .x       (x),
    .y       (y),
    .u       (u),
    .s       (s),
    .a       (a),
    .b       (b),
    .ofs     (ofs),
    .ea_pre  (ea_pre),
    .upd_val (calc_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else if (cen) state <= state_nx;
  end

  // Bus handshake outputs are decoded from the state so a read completes
  // in the same cycle it is requested.
  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    rd_addr  = '0;
    pc_inc   = 1'b0;
    idx_busy = 1'b1;
    upd_en   = 1'b0;
    upd_sel  = '0;
    upd_val  = '0;
    case (state)
      ST_IDLE: begin
        idx_busy = idx_en & cen;
        if (idx_en) state_nx = ST_POSTB;
      end
      ST_POSTB: begin
        rd      = 1'b1;
        rd_addr = pc;
        pc_inc  = cen & ~mem_busy;
        if (!mem_busy) begin
          case (din_pb.mode)
            MODE_N8:            state_nx = ST_OFS_LO;
            MODE_N16, MODE_EXT: state_nx = ST_OFS_HI;
            default:            state_nx = ST_CALC;
          endcase
        end
      end
      ST_OFS_HI: begin
        rd      = 1'b1;
        rd_addr = pc;
        pc_inc  = cen & ~mem_busy;
        if (!mem_busy) state_nx = ST_OFS_LO;
      end
      ST_OFS_LO: begin
        rd      = 1'b1;
        rd_addr = pc;
        pc_inc  = cen & ~mem_busy;
        if (!mem_busy) state_nx = ST_CALC;
      end
      ST_CALC: begin
        if (postb.mode < MODE_ACC) begin
          upd_en  = cen;
          upd_sel = postb.rsel;
          upd_val = calc_upd;
        end
        state_nx = postb.ind ? ST_IND_HI : ST_DONE;
      end
      ST_IND_HI: begin
        rd      = 1'b1;
        rd_addr = ea;
        if (!mem_busy) state_nx = ST_IND_LO;
      end
      ST_IND_LO: begin
        rd      = 1'b1;
        rd_addr = ea + AW'(1);
        if (!mem_busy) state_nx = ST_DONE;
      end
      ST_DONE: begin
        idx_busy = 1'b0;
        state_nx = ST_IDLE;
      end
      default: begin
        idx_busy = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Captured bytes and EA; ea keeps the pre-indirect address for IND reads
  always_ff @(posedge clk) begin
    if (rst) begin
      postb  <= '0;
      ofs    <= '0;
      ind_hi <= '0;
      ea     <= '0;
    end else if (cen) begin
      case (state)
        ST_IDLE:   if (idx_en) ofs <= '0;
        ST_POSTB:  if (!mem_busy) postb <= din_pb;
        ST_OFS_HI: if (!mem_busy) ofs[AW-1:DW] <= din;
        ST_OFS_LO: if (!mem_busy) ofs[DW-1:0] <= din;
        ST_CALC:   ea <= ea_pre;
        ST_IND_HI: if (!mem_busy) ind_hi <= din;
        ST_IND_LO: if (!mem_busy) ea <= {ind_hi, din};
        default: ;
      endcase
    end
  end

endmodule
